// File: rtl/hi_fanin_pkg.sv
// Shared types and helpers for the hi_fanin_collector fan-in block.
package hi_fanin_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Widest one-hot vector the index helper accepts; callers zero-extend.
    localparam int MAX_SRC = 256;

    function automatic int src_id_w(input int n);
        return $clog2(n);
    endfunction

    // OR of the indices of all set bits; exact for a one-hot or zero input.
    function automatic int unsigned onehot_to_index(input logic [MAX_SRC-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_SRC; i++) begin
            if (oh[i]) idx = idx | int'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hi_fanin_rr_pick.sv
// Combinational round-robin picker: first pending source at or after i_rr_ptr,
// wrapping from NUM_SRC-1 back to 0.
module hi_fanin_rr_pick
    import hi_fanin_pkg::*;
#(
    parameter int NUM_SRC  = 35,
    parameter int SRC_ID_W = src_id_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]  i_pend,
    input  logic [SRC_ID_W-1:0] i_rr_ptr,
    output logic [NUM_SRC-1:0]  o_grant,
    output logic [SRC_ID_W-1:0] o_grant_id,
    output logic                o_any
);

    logic [NUM_SRC-1:0] w_mask;
    logic [NUM_SRC-1:0] w_hi;
    logic [NUM_SRC-1:0] w_sel;

    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    assign w_mask = ~((NUM_SRC'(1) << i_rr_ptr) - NUM_SRC'(1));
    assign w_hi   = i_pend & w_mask;
    assign w_sel  = (|w_hi) ? w_hi : i_pend;

    assign o_grant    = w_sel & (~w_sel + NUM_SRC'(1));
    assign o_grant_id = SRC_ID_W'(onehot_to_index(MAX_SRC'(o_grant)));
    assign o_any      = |i_pend;

endmodule

// File: rtl/hi_fanin_collector.sv
// NUM_SRC one-deep capture buffers merged by a round-robin arbiter onto one
// registered valid/ready stream. Define FANIN_OVF_EN for sticky drop flags.
module hi_fanin_collector
    import hi_fanin_pkg::*;
#(
    parameter  int NUM_SRC  = 35,
    parameter  int DATA_W   = 1,
    localparam int SRC_ID_W = src_id_w(NUM_SRC)
) (
    input  logic                      clk1,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_pending,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_ID_W-1:0]       out_src_id,
    output logic [NUM_SRC-1:0]        src_ovf
);

    logic [1:0]                r_rst_sync;
    logic                      w_rst_n;
    state_t                    r_state;
    state_t                    w_state_next;
    logic [NUM_SRC-1:0]        r_pend;
    logic [NUM_SRC*DATA_W-1:0] r_buf;
    logic [SRC_ID_W-1:0]       r_rr_ptr;
    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_data;
    logic [SRC_ID_W-1:0]       r_out_src_id;
    logic [NUM_SRC-1:0]        w_grant;
    logic [SRC_ID_W-1:0]       w_grant_id;
    logic                      w_any;
    logic                      w_load;
    logic [NUM_SRC-1:0]        w_take;
    logic [DATA_W-1:0]         w_sel_data;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    hi_fanin_rr_pick #(
        .NUM_SRC  (NUM_SRC),
        .SRC_ID_W (SRC_ID_W)
    ) u_pick (
        .i_pend     (r_pend),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = 1'b1;
                if (w_any) w_state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    w_load       = 1'b1;
                    w_state_next = w_any ? HOLD : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_take = (w_load && w_any) ? w_grant : '0;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_grant[i]) w_sel_data = w_sel_data | r_buf[i*DATA_W +: DATA_W];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk1 or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // NOTE: the capture buffers are reset with everything else so no stale payload survives a reset.
    always_ff @(posedge clk1 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pend <= '0;
            r_buf  <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_take[i]) begin
                    r_pend[i] <= src_valid[i];
                    if (src_valid[i]) r_buf[i*DATA_W +: DATA_W] <= src_data[i*DATA_W +: DATA_W];
                end else if (src_valid[i] && !r_pend[i]) begin
                    r_pend[i]                  <= 1'b1;
                    r_buf[i*DATA_W +: DATA_W] <= src_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk1 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src_id <= '0;
            r_rr_ptr     <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_sel_data;
                r_out_src_id <= w_grant_id;
                r_rr_ptr     <= (w_grant_id == SRC_ID_W'(NUM_SRC - 1)) ? '0
                                                                     : w_grant_id + SRC_ID_W'(1);
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef FANIN_OVF_EN
    logic [NUM_SRC-1:0] r_ovf;

    always_ff @(posedge clk1 or negedge w_rst_n) begin
        if (!w_rst_n) r_ovf <= '0;
        else          r_ovf <= r_ovf | (src_valid & r_pend & ~w_take);
    end
    assign src_ovf = r_ovf;
`else
    assign src_ovf = '0;
`endif

    assign src_pending = r_pend;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_src_id  = r_out_src_id;

endmodule

// File: tb/tb_hi_fanin_collector.sv
// Scoreboard bench for hi_fanin_collector: a queue-based reference model predicts
// the granted word stream; a negedge monitor compares each accepted transfer.
module tb_hi_fanin_collector;

    localparam int NUM_SRC = 35;
    localparam int DATA_W  = 1;
    localparam int ID_W    = $clog2(NUM_SRC);
`ifdef FANIN_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
    } word_t;

    logic                      clk1 = 1'b0;
    logic                      rst_n;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_pending;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_src_id;
    logic [NUM_SRC-1:0]        src_ovf;

    always #5 clk1 = ~clk1;

    hi_fanin_collector #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_pending (src_pending),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_src_id  (out_src_id),
        .src_ovf     (src_ovf)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    word_t exp_q[$];
    int    got_ids[$];
    word_t mon_w;

    // Reference model: buffers, pending flags, pointer and whether a word is held.
    logic [NUM_SRC-1:0] m_pend;
    logic [NUM_SRC-1:0] m_ovf;
    logic [DATA_W-1:0]  m_buf [NUM_SRC];
    int                 m_ptr;
    bit                 m_valid;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_ovf   = '0;
        foreach (m_buf[i]) m_buf[i] = '0;
        m_ptr   = 0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    // Effect of the next clock edge given the inputs currently applied.
    task automatic model_step();
        bit    load;
        int    take;
        word_t w;
        take = -1;
        load = !m_valid || out_ready;
        if (load) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                int idx;
                idx = (m_ptr + k) % NUM_SRC;
                if (take < 0 && m_pend[idx]) take = idx;
            end
            if (take >= 0) begin
                w.id   = take;
                w.data = m_buf[take];
                exp_q.push_back(w);
                m_valid = 1'b1;
                m_ptr   = (take + 1) % NUM_SRC;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i]) begin
                if (!m_pend[i] || i == take) begin
                    m_pend[i] = 1'b1;
                    m_buf[i]  = src_data[i*DATA_W +: DATA_W];
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end else if (i == take) begin
                m_pend[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk1);
        #1;
    endtask

    function automatic logic [NUM_SRC-1:0] rand_vec();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[NUM_SRC-1:0];
    endfunction

    task automatic rand_data();
        for (int i = 0; i < NUM_SRC; i++) src_data[i*DATA_W +: DATA_W] = DATA_W'($urandom());
    endtask

    function automatic int got_at(input int i);
        return (got_ids.size() > i) ? got_ids[i] : -1;
    endfunction

    task automatic run_random(input int n);
        for (int c = 0; c < n; c++) begin
            src_valid = rand_vec() & rand_vec() & rand_vec();
            rand_data();
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            check("rnd_pending", src_pending, m_pend);
            check("rnd_ovf", src_ovf, m_ovf & {NUM_SRC{OVF_EN}});
        end
        src_valid = '0;
    endtask

    always @(negedge clk1) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got word id %0d, expected no word at %0t", out_src_id, $time);
            end else begin
                mon_w = exp_q.pop_front();
                check("sb_id", out_src_id, mon_w.id);
                check("sb_data", out_data, mon_w.data);
            end
            got_ids.push_back(int'(out_src_id));
        end
    end

    logic [DATA_W-1:0] d5;

    initial begin
        rst_n     = 1'b0;
        src_valid = '0;
        src_data  = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk1);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_pending", src_pending, 0);
        check("rst_ovf", src_ovf, 0);
        check("rst_src_id", out_src_id, 0);
        check("rst_data", out_data, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", out_valid, 0);

        // Burst: every source at once drains as ids 0..34 with no gaps.
        out_ready = 1'b1;
        src_valid = '1;
        rand_data();
        tick();
        src_valid = '0;
        tick();
        for (int k = 0; k < NUM_SRC; k++) begin
            check("t2_valid", out_valid, 1);
            check("t2_id", out_src_id, k);
            tick();
        end
        check("t2_done", out_valid, 0);

        // Single capture from source 7.
        src_valid = NUM_SRC'(1) << 7;
        src_data  = '0;
        src_data[7*DATA_W +: DATA_W] = DATA_W'(1);
        tick();
        src_valid = '0;
        check("t1_pending", src_pending[7], 1);
        check("t1_not_yet", out_valid, 0);
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_id", out_src_id, 7);
        check("t1_data", out_data, 1);
        tick();
        check("t1_idle", out_valid, 0);

        // Stall on id 5 while source 3 is captured, then overrun.
        out_ready = 1'b0;
        d5        = DATA_W'($urandom());
        rand_data();
        src_data[5*DATA_W +: DATA_W] = d5;
        src_valid = (NUM_SRC'(1) << 5) | (NUM_SRC'(1) << 6);
        tick();
        src_valid = NUM_SRC'(1) << 3;
        src_data[3*DATA_W +: DATA_W] = DATA_W'(1);
        tick();
        check("t3_valid", out_valid, 1);
        check("t3_id", out_src_id, 5);
        src_data[3*DATA_W +: DATA_W] = DATA_W'(0);
        tick();
        src_valid = '0;
        for (int c = 0; c < 10; c++) begin
            check("t3_stall_valid", out_valid, 1);
            check("t3_stall_id", out_src_id, 5);
            check("t3_stall_data", out_data, d5);
            tick();
        end
        check("t4_ovf3", src_ovf[3], OVF_EN);
        check("t4_pend3", src_pending[3], 1);
        out_ready = 1'b1;
        tick();
        check("t3_next_id", out_src_id, 6);
        tick();
        check("t4_id3", out_src_id, 3);
        check("t4_id3_data", out_data, 1);
        tick();
        check("t4_idle", out_valid, 0);

        // Pointer wrap: park the pointer at 34, then pend on 34 and 0.
        src_valid = NUM_SRC'(1) << 33;
        tick();
        src_valid = '0;
        repeat (3) tick();
        got_ids.delete();
        src_valid = (NUM_SRC'(1) << 34) | NUM_SRC'(1);
        rand_data();
        tick();
        src_valid = '0;
        repeat (4) tick();
        src_valid = NUM_SRC'(3);
        tick();
        src_valid = '0;
        repeat (4) tick();
        check("t5_count", got_ids.size(), 4);
        check("t5_first", got_at(0), 34);
        check("t5_second", got_at(1), 0);
        check("t5_ptr1_first", got_at(2), 1);
        check("t5_ptr1_second", got_at(3), 0);

        run_random(400);

        // Reset in the middle of a burst.
        out_ready = 1'b1;
        src_valid = '1;
        rand_data();
        tick();
        src_valid = '0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_drop", out_valid, 0);
        check("t6_pending_clr", src_pending, 0);
        check("t6_ovf_clr", src_ovf, 0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("t6_no_stale", out_valid, 0);
        check("t6_pending_idle", src_pending, 0);

        run_random(400);

        src_valid = '0;
        out_ready = 1'b1;
        repeat (NUM_SRC + 5) tick();
        check("drain_queue", exp_q.size(), 0);
        check("drain_idle", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
